serv_bus_arbiter: RTL and testbench

Two-into-one Wishbone classic arbiter that lets the SERV core's instruction bus and data bus share a single memory port. It sits between the core's `o_ibus_*`/`o_dbus_*` pins and the system memory, and holds a grant for the full duration of each transaction. It alternates grants fairly when both buses request in the same cycle. A per-transaction watchdog terminates any cycle the slave never acknowledges, answering it with an error ack.

---
 rtl/serv_bus_arbiter.sv | 84 ++++++++
 tb/tb_serv_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter: shares one Wishbone port between SERV's ibus and dbus,
// holding each grant until ack, abort or watchdog timeout.
module serv_bus_arbiter #(
    parameter int TIMEOUT_W  = 8,
    parameter int TIMEOUT_EN = 1
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    output logic        o_ibus_err,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic        o_dbus_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 gnt_i, gnt_d, owner_cyc, timeout, wb_ack, done;

    assign gnt_i     = state_q == GNT_I;
    assign gnt_d     = state_q == GNT_D;
    assign owner_cyc = gnt_i ? i_ibus_cyc : gnt_d & i_dbus_cyc;
    assign timeout   = (TIMEOUT_EN != 0) && state_q != IDLE && (&tmo_q);
    assign wb_ack    = i_wb_ack & o_wb_cyc;
    // An owner dropping cyc, an ack, or the watchdog all end the grant.
    assign done      = state_q != IDLE && (!owner_cyc || wb_ack || timeout);

    assign o_wb_cyc = owner_cyc & !timeout;
    assign o_wb_adr = gnt_i ? i_ibus_adr : gnt_d ? i_dbus_adr : 32'h0;
    assign o_wb_dat = gnt_d ? i_dbus_dat : 32'h0;
    assign o_wb_sel = gnt_i ? 4'hf : gnt_d ? i_dbus_sel : 4'h0;
    assign o_wb_we  = gnt_d & i_dbus_we;

    assign o_ibus_ack = gnt_i & (wb_ack | timeout);
    assign o_dbus_ack = gnt_d & (wb_ack | timeout);
    assign o_ibus_err = gnt_i & timeout;
    assign o_dbus_err = gnt_d & timeout;
    assign o_ibus_rdt = timeout ? 32'h0 : i_wb_rdt;
    assign o_dbus_rdt = timeout ? 32'h0 : i_wb_rdt;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

    // last_q is 1 when dbus held the previous grant, so ties go to the other bus.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        tmo_d   = '0;
        if (state_q == IDLE) begin
            state_d = i_ibus_cyc && (!i_dbus_cyc || last_q) ? GNT_I : i_dbus_cyc ? GNT_D : IDLE;
        end else if (done) begin
            state_d = IDLE;
            last_d  = gnt_d;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_serv_bus_arbiter.sv
// tb_serv_bus_arbiter: directed and random checks of serv_bus_arbiter
// against a transaction-level model of grants, ages and the last owner.
module tb_serv_bus_arbiter;
    localparam int TW = 4;
    localparam int TMO = (1 << TW) - 1;

    logic        clk = 1'b0, i_rst = 1'b1;
    logic [31:0] i_ibus_adr = '0, i_dbus_adr = '0, i_dbus_dat = '0, i_wb_rdt = '0;
    logic        i_ibus_cyc = 1'b0, i_dbus_cyc = 1'b0, i_dbus_we = 1'b0, i_wb_ack = 1'b0;
    logic [3:0]  i_dbus_sel = '0;
    logic [31:0] o_ibus_rdt, o_dbus_rdt, o_wb_adr, o_wb_dat;
    logic        o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err, o_wb_we, o_wb_cyc;
    logic [3:0]  o_wb_sel;

    int checks = 0, passed = 0, fails = 0;
    int m_own = 0, m_age = 0;
    bit m_last = 1'b1;
    int got;

    serv_bus_arbiter #(.TIMEOUT_W(TW), .TIMEOUT_EN(1)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_rdt(o_ibus_rdt),
        .o_ibus_ack(o_ibus_ack), .o_ibus_err(o_ibus_err),
        .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
        .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc), .o_dbus_rdt(o_dbus_rdt),
        .o_dbus_ack(o_dbus_ack), .o_dbus_err(o_dbus_err),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Owner: 0 none, 1 ibus, 2 dbus. Age counts granted cycles without completion.
    task automatic check_all();
        logic own_cyc, tmo, ecyc, eack;
        own_cyc = m_own == 1 ? i_ibus_cyc : m_own == 2 ? i_dbus_cyc : 1'b0;
        tmo     = m_own != 0 && m_age == TMO;
        ecyc    = own_cyc && !tmo;
        eack    = tmo || (ecyc && i_wb_ack);
        chk("wb_cyc", o_wb_cyc, ecyc);
        chk("wb_adr", o_wb_adr, m_own == 1 ? i_ibus_adr : m_own == 2 ? i_dbus_adr : 32'h0);
        chk("wb_dat", o_wb_dat, m_own == 2 ? i_dbus_dat : 32'h0);
        chk("wb_sel", o_wb_sel, m_own == 1 ? 4'hf : m_own == 2 ? i_dbus_sel : 4'h0);
        chk("wb_we", o_wb_we, m_own == 2 && i_dbus_we);
        chk("ibus_ack", o_ibus_ack, m_own == 1 && eack);
        chk("ibus_err", o_ibus_err, m_own == 1 && tmo);
        chk("dbus_ack", o_dbus_ack, m_own == 2 && eack);
        chk("dbus_err", o_dbus_err, m_own == 2 && tmo);
        chk("ibus_rdt", o_ibus_rdt, tmo ? 32'h0 : i_wb_rdt);
        chk("dbus_rdt", o_dbus_rdt, tmo ? 32'h0 : i_wb_rdt);
    endtask

    task automatic settle();
        #3;
        check_all();
    endtask

    task automatic advance();
        logic own_cyc;
        @(posedge clk);
        own_cyc = m_own == 1 ? i_ibus_cyc : m_own == 2 ? i_dbus_cyc : 1'b0;
        if (m_own == 0) begin
            m_age = 0;
            if (i_ibus_cyc && i_dbus_cyc) m_own = m_last ? 1 : 2;
            else if (i_ibus_cyc) m_own = 1;
            else if (i_dbus_cyc) m_own = 2;
        end else if (!own_cyc || m_age == TMO || i_wb_ack) begin
            m_last = m_own == 2;
            m_own = 0;
            m_age = 0;
        end else begin
            m_age++;
        end
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic model_reset();
        m_own = 0;
        m_age = 0;
        m_last = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        settle();
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        // ibus-only fetch
        i_ibus_adr = 32'h8;
        i_ibus_cyc = 1'b1;
        tick();
        settle();
        chk("ifetch_cyc", o_wb_cyc, 1'b1);
        chk("ifetch_adr", o_wb_adr, 32'h8);
        advance();
        i_wb_ack = 1'b1;
        i_wb_rdt = 32'h13;
        settle();
        chk("ifetch_ack", o_ibus_ack, 1'b1);
        chk("ifetch_rdt", o_ibus_rdt, 32'h13);
        chk("ifetch_dack", o_dbus_ack, 1'b0);
        advance();
        i_wb_ack = 1'b0;
        i_ibus_cyc = 1'b0;
        tick();
        // both held: ibus just finished, so the order is D,I,D,I
        i_ibus_cyc = 1'b1;
        i_dbus_cyc = 1'b1;
        i_ibus_adr = 32'h100;
        i_dbus_adr = 32'h2000;
        for (int j = 0; j < 4; j++) begin
            tick();
            tick();
            i_wb_ack = 1'b1;
            settle();
            chk("alt_iack", o_ibus_ack, j % 2 == 1);
            chk("alt_dack", o_dbus_ack, j % 2 == 0);
            advance();
            i_wb_ack = 1'b0;
        end
        i_ibus_cyc = 1'b0;
        i_dbus_cyc = 1'b0;
        tick();
        // dbus write
        i_dbus_adr = 32'h1000;
        i_dbus_dat = 32'hdeadbeef;
        i_dbus_sel = 4'b0011;
        i_dbus_we = 1'b1;
        i_dbus_cyc = 1'b1;
        tick();
        settle();
        chk("wr_adr", o_wb_adr, 32'h1000);
        chk("wr_dat", o_wb_dat, 32'hdeadbeef);
        chk("wr_sel", o_wb_sel, 4'b0011);
        chk("wr_we", o_wb_we, 1'b1);
        advance();
        i_wb_ack = 1'b1;
        settle();
        chk("wr_ack", o_dbus_ack, 1'b1);
        chk("wr_err", o_dbus_err, 1'b0);
        advance();
        i_wb_ack = 1'b0;
        i_dbus_cyc = 1'b0;
        tick();
        // unanswered dbus read hits the watchdog
        i_dbus_we = 1'b0;
        i_dbus_sel = 4'hf;
        i_dbus_cyc = 1'b1;
        i_wb_rdt = 32'habcdef01;
        got = 0;
        tick();
        for (int k = 1; k <= 40; k++) begin
            settle();
            if (o_dbus_ack && got == 0) begin
                got = k;
                chk("tmo_err", o_dbus_err, 1'b1);
                chk("tmo_rdt", o_dbus_rdt, 32'h0);
                chk("tmo_cyc", o_wb_cyc, 1'b0);
            end
            advance();
            if (got != 0) break;
        end
        chk("tmo_latency", got, 16);
        i_dbus_cyc = 1'b0;
        i_wb_ack = 1'b1;
        tick();
        settle();
        chk("stray_ack", {o_ibus_ack, o_dbus_ack}, 2'b00);
        advance();
        i_wb_ack = 1'b0;
        // ibus aborts with a simultaneous ack while dbus waits
        i_ibus_cyc = 1'b1;
        i_dbus_cyc = 1'b1;
        i_ibus_adr = 32'h40;
        i_dbus_adr = 32'h3000;
        tick();
        settle();
        chk("abort_grant_i", o_wb_adr, 32'h40);
        advance();
        i_ibus_cyc = 1'b0;
        i_wb_ack = 1'b1;
        settle();
        chk("abort_noack", o_ibus_ack, 1'b0);
        chk("abort_cyc", o_wb_cyc, 1'b0);
        advance();
        i_wb_ack = 1'b0;
        settle();
        chk("abort_idle", o_wb_cyc, 1'b0);
        advance();
        settle();
        chk("abort_then_d", o_wb_adr, 32'h3000);
        advance();
        i_wb_ack = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        i_dbus_cyc = 1'b0;
        tick();
        // random traffic
        for (int r = 0; r < 400; r++) begin
            i_ibus_cyc = $urandom_range(0, 3) != 0;
            i_dbus_cyc = $urandom_range(0, 3) != 0;
            i_ibus_adr = $urandom;
            i_dbus_adr = $urandom;
            i_dbus_dat = $urandom;
            i_dbus_sel = 4'($urandom);
            i_dbus_we = 1'($urandom);
            i_wb_rdt = $urandom;
            i_wb_ack = $urandom_range(0, 3) == 0;
            tick();
        end
        i_ibus_cyc = 1'b0;
        i_dbus_cyc = 1'b0;
        i_wb_ack = 1'b0;
        i_wb_rdt = 32'h0;
        repeat (3) tick();
        // asynchronous reset mid-grant, then a tie goes to ibus
        i_ibus_cyc = 1'b1;
        i_dbus_cyc = 1'b1;
        i_ibus_adr = 32'h80;
        i_dbus_adr = 32'h4000;
        tick();
        tick();
        i_wb_ack = 1'b1;
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        chk("arst_cyc", o_wb_cyc, 1'b0);
        chk("arst_ack", {o_ibus_ack, o_dbus_ack}, 2'b00);
        check_all();
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        i_wb_ack = 1'b0;
        tick();
        settle();
        chk("tie_after_rst", o_wb_adr, 32'h80);
        advance();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
